// File: rtl/img_bbox_locator_pkg.sv
// img_bbox_locator_pkg: geometry defaults and FSM encoding shared by the bounding-box locator files.
package img_bbox_locator_pkg;
    localparam int IMG_W_DEF      = 640;
    localparam int IMG_H_DEF      = 480;
    localparam int COORD_W_DEF    = 10;
    localparam int CNT_W_DEF      = 19;
    localparam int MIN_PIXELS_DEF = 16;
    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        ACTIVE   = 2'd1,
        LATCH    = 2'd2
    } state_t;
endpackage

// File: rtl/img_bbox_locator_if.sv
// img_bbox_locator_if: binary pixel stream in, per-frame bounding-box result out.
interface img_bbox_locator_if
    import img_bbox_locator_pkg::*;
#(
    parameter int COORD_W = COORD_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
);
    logic               pre_vs;
    logic               pre_hs;
    logic               pre_clken;
    logic               pre_imgbit;
    logic               box_valid;
    logic               box_found;
    logic [COORD_W-1:0] box_xmin;
    logic [COORD_W-1:0] box_xmax;
    logic [COORD_W-1:0] box_ymin;
    logic [COORD_W-1:0] box_ymax;
    logic [CNT_W-1:0]   box_count;
    modport master (
        output pre_vs, pre_hs, pre_clken, pre_imgbit,
        input  box_valid, box_found, box_xmin, box_xmax, box_ymin, box_ymax, box_count
    );
    modport slave (
        input  pre_vs, pre_hs, pre_clken, pre_imgbit,
        output box_valid, box_found, box_xmin, box_xmax, box_ymin, box_ymax, box_count
    );
endinterface

// File: rtl/img_bbox_locator_acc.sv
// bbox_minmax_acc: running min/max of foreground coordinates plus a saturating pixel count.
module bbox_minmax_acc
    import img_bbox_locator_pkg::*;
#(
    parameter int IMG_W   = IMG_W_DEF,
    parameter int IMG_H   = IMG_H_DEF,
    parameter int COORD_W = COORD_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr_i,
    input  logic               en_i,
    input  logic [COORD_W-1:0] x_i,
    input  logic [COORD_W-1:0] y_i,
    output logic [COORD_W-1:0] xmin_o,
    output logic [COORD_W-1:0] xmax_o,
    output logic [COORD_W-1:0] ymin_o,
    output logic [COORD_W-1:0] ymax_o,
    output logic [CNT_W-1:0]   cnt_o
);
    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(IMG_W - 1);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(IMG_H - 1);
    logic [COORD_W-1:0] xmin_q, xmin_d, xmax_q, xmax_d, ymin_q, ymin_d, ymax_q, ymax_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    // mins start at the far corner so the first foreground pixel always wins
    always_comb begin
        xmin_d = clr_i ? X_LAST : (en_i && x_i < xmin_q) ? x_i : xmin_q;
        xmax_d = clr_i ? '0     : (en_i && x_i > xmax_q) ? x_i : xmax_q;
        ymin_d = clr_i ? Y_LAST : (en_i && y_i < ymin_q) ? y_i : ymin_q;
        ymax_d = clr_i ? '0     : (en_i && y_i > ymax_q) ? y_i : ymax_q;
        cnt_d  = clr_i ? '0     : (en_i && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xmin_q <= X_LAST;
            xmax_q <= '0;
            ymin_q <= Y_LAST;
            ymax_q <= '0;
            cnt_q  <= '0;
        end else begin
            xmin_q <= xmin_d;
            xmax_q <= xmax_d;
            ymin_q <= ymin_d;
            ymax_q <= ymax_d;
            cnt_q  <= cnt_d;
        end
    end
    assign xmin_o = xmin_q;
    assign xmax_o = xmax_q;
    assign ymin_o = ymin_q;
    assign ymax_o = ymax_q;
    assign cnt_o  = cnt_q;
endmodule

// File: rtl/img_bbox_locator.sv
// img_bbox_locator: per-frame foreground pixel count and bounding box of a binary pixel stream.
module img_bbox_locator
    import img_bbox_locator_pkg::*;
#(
    parameter int IMG_W      = IMG_W_DEF,
    parameter int IMG_H      = IMG_H_DEF,
    parameter int COORD_W    = COORD_W_DEF,
    parameter int CNT_W      = CNT_W_DEF,
    parameter int MIN_PIXELS = MIN_PIXELS_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    img_bbox_locator_if.slave   pix_bus
);
    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(IMG_W - 1);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(IMG_H - 1);
    state_t             state_q, state_d;
    logic               vs_q, hs_q;
    logic [COORD_W-1:0] col_q, col_d, row_q, row_d;
    logic               valid_q, valid_d, found_q, found_d;
    logic [COORD_W-1:0] xmin_q, xmin_d, xmax_q, xmax_d, ymin_q, ymin_d, ymax_q, ymax_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               vs_rise, vs_fall, hs_fall, act, lat, pix, clr, empty;
    logic [COORD_W-1:0] acc_xmin, acc_xmax, acc_ymin, acc_ymax;
    logic [CNT_W-1:0]   acc_cnt;
    assign vs_rise = pix_bus.pre_vs & ~vs_q;
    assign vs_fall = ~pix_bus.pre_vs & vs_q;
    assign hs_fall = ~pix_bus.pre_hs & hs_q;
    assign act     = state_q == ACTIVE;
    assign lat     = state_q == LATCH;
    assign pix     = act & pix_bus.pre_hs & pix_bus.pre_clken;
    assign clr     = vs_rise;
    assign empty   = acc_cnt == '0;
    bbox_minmax_acc #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .COORD_W(COORD_W), .CNT_W(CNT_W)
    ) u_acc (
        .clk(clk), .rst_n(rst_n), .clr_i(clr), .en_i(pix & pix_bus.pre_imgbit),
        .x_i(col_q), .y_i(row_q),
        .xmin_o(acc_xmin), .xmax_o(acc_xmax), .ymin_o(acc_ymin), .ymax_o(acc_ymax), .cnt_o(acc_cnt)
    );
    // a vs rise in any state restarts the frame, so a LATCH cycle never swallows the next SOF
    always_comb begin
        state_d = state_q == WAIT_SOF ? (vs_rise ? ACTIVE : WAIT_SOF)
                : state_q == ACTIVE   ? (vs_fall ? LATCH : ACTIVE)
                :                       (vs_rise ? ACTIVE : WAIT_SOF);
        col_d   = clr ? '0 : pix ? (col_q == X_LAST ? col_q : col_q + COORD_W'(1))
                : (act && hs_fall) ? '0 : col_q;
        row_d   = clr ? '0 : (act && hs_fall) ? (row_q == Y_LAST ? row_q : row_q + COORD_W'(1)) : row_q;
        valid_d = lat;
        found_d = lat ? acc_cnt >= CNT_W'(MIN_PIXELS) : found_q;
        xmin_d  = lat ? (empty ? '0 : acc_xmin) : xmin_q;
        xmax_d  = lat ? (empty ? '0 : acc_xmax) : xmax_q;
        ymin_d  = lat ? (empty ? '0 : acc_ymin) : ymin_q;
        ymax_d  = lat ? (empty ? '0 : acc_ymax) : ymax_q;
        count_d = lat ? acc_cnt : count_q;
    end
    // vs_q resets high so a reset released mid-frame cannot fake a start of frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WAIT_SOF;
            vs_q    <= 1'b1;
            hs_q    <= 1'b0;
            col_q   <= '0;
            row_q   <= '0;
            valid_q <= 1'b0;
            found_q <= 1'b0;
            xmin_q  <= '0;
            xmax_q  <= '0;
            ymin_q  <= '0;
            ymax_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            vs_q    <= pix_bus.pre_vs;
            hs_q    <= pix_bus.pre_hs;
            col_q   <= col_d;
            row_q   <= row_d;
            valid_q <= valid_d;
            found_q <= found_d;
            xmin_q  <= xmin_d;
            xmax_q  <= xmax_d;
            ymin_q  <= ymin_d;
            ymax_q  <= ymax_d;
            count_q <= count_d;
        end
    end
    assign pix_bus.box_valid = valid_q;
    assign pix_bus.box_found = found_q;
    assign pix_bus.box_xmin  = xmin_q;
    assign pix_bus.box_xmax  = xmax_q;
    assign pix_bus.box_ymin  = ymin_q;
    assign pix_bus.box_ymax  = ymax_q;
    assign pix_bus.box_count = count_q;
endmodule

// File: tb/tb_img_bbox_locator.sv
// tb_img_bbox_locator: directed frames on an 8x4 image; expected boxes queued, monitor checks each box_valid.
module tb_img_bbox_locator;
    localparam int W = 8, H = 4, CW = 4, NW = 8, MP = 2;
    typedef struct packed {
        logic          found;
        logic [CW-1:0] xmin, xmax, ymin, ymax;
        logic [NW-1:0] cnt;
        logic [31:0]   cyc;
    } exp_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    img_bbox_locator_if #(.COORD_W(CW), .CNT_W(NW)) bif();
    img_bbox_locator #(
        .IMG_W(W), .IMG_H(H), .COORD_W(CW), .CNT_W(NW), .MIN_PIXELS(MP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pix_bus(bif)
    );
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask
    function automatic exp_t mk(input logic f, input int x0, input int x1, input int y0, input int y1, input int n);
        mk = '{f, CW'(x0), CW'(x1), CW'(y0), CW'(y1), NW'(n), 32'd0};
    endfunction
    task automatic drv(input logic vs, input logic hs, input logic ck, input logic b);
        bif.pre_vs = vs;
        bif.pre_hs = hs;
        bif.pre_clken = ck;
        bif.pre_imgbit = b;
        @(negedge clk);
    endtask
    task automatic expect_box(input exp_t e);
        e.cyc = cyc + 2;
        exp_q.push_back(e);
    endtask
    task automatic chk_zero(input string nm);
        chk({nm, "_valid"}, 32'(bif.box_valid), 0);
        chk({nm, "_found"}, 32'(bif.box_found), 0);
        chk({nm, "_xmin"}, 32'(bif.box_xmin), 0);
        chk({nm, "_xmax"}, 32'(bif.box_xmax), 0);
        chk({nm, "_ymin"}, 32'(bif.box_ymin), 0);
        chk({nm, "_ymax"}, 32'(bif.box_ymax), 0);
        chk({nm, "_count"}, 32'(bif.box_count), 0);
    endtask
    // rows[8*y+x] = foreground at (x,y); late_fall drops vs on the very last pixel
    task automatic frame(input logic [31:0] rows, input bit late_fall, input exp_t e);
        drv(1, 0, 0, 0);
        drv(1, 0, 0, 0);
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                if (late_fall && y == H - 1 && x == W - 1) begin
                    expect_box(e);
                    drv(0, 1, 1, rows[8*y+x]);
                end else drv(1, 1, 1, rows[8*y+x]);
            end
            if (!(late_fall && y == H - 1)) drv(1, 0, 0, 0);
        end
        if (!late_fall) begin
            expect_box(e);
            drv(0, 0, 0, 0);
        end
        repeat (4) drv(0, 0, 0, 0);
    endtask
    task automatic long_line(input int n, input exp_t e);
        drv(1, 0, 0, 0);
        drv(1, 0, 0, 0);
        repeat (4) drv(1, 0, 1, 1);
        repeat (n) drv(1, 1, 1, 1);
        drv(1, 0, 0, 0);
        expect_box(e);
        drv(0, 0, 0, 0);
        repeat (4) drv(0, 0, 0, 0);
    endtask
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bif.box_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_valid actual=1 required=0 (cycle %0d)", cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("found", 32'(bif.box_found), 32'(e.found));
                    chk("xmin", 32'(bif.box_xmin), 32'(e.xmin));
                    chk("xmax", 32'(bif.box_xmax), 32'(e.xmax));
                    chk("ymin", 32'(bif.box_ymin), 32'(e.ymin));
                    chk("ymax", 32'(bif.box_ymax), 32'(e.ymax));
                    chk("count", 32'(bif.box_count), 32'(e.cnt));
                    chk("latency_cycle", 32'(cyc), e.cyc);
                end
            end
        end
    end
    initial begin : stim
        bif.pre_vs = 0;
        bif.pre_hs = 0;
        bif.pre_clken = 0;
        bif.pre_imgbit = 0;
        @(negedge clk);
        repeat (4) begin
            drv(1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)));
            chk_zero("reset");
        end
        drv(0, 0, 0, 0);
        rst_n = 1'b1;
        repeat (3) drv(0, 0, 0, 0);
        chk_zero("post_reset");
        frame(32'h0, 0, mk(0, 0, 0, 0, 0, 0));
        frame(32'h08_00_24_00, 0, mk(1, 2, 5, 1, 3, 3));
        repeat (3) drv(0, 0, 0, 0);
        chk("hold_count", 32'(bif.box_count), 3);
        chk("hold_xmax", 32'(bif.box_xmax), 5);
        chk("hold_valid", 32'(bif.box_valid), 0);
        frame(32'h80_00_00_00, 1, mk(0, 7, 7, 3, 3, 1));
        drv(1, 0, 0, 0);
        repeat (4) drv(1, 1, 1, 1);
        rst_n = 1'b0;
        drv(1, 1, 1, 1);
        chk_zero("mid_frame_reset");
        rst_n = 1'b1;
        repeat (3) drv(1, 1, 1, 1);
        drv(1, 0, 0, 0);
        repeat (8) drv(1, 1, 1, 1);
        drv(1, 0, 0, 0);
        repeat (5) drv(0, 0, 0, 0);
        frame(32'h00_00_00_01, 0, mk(0, 0, 0, 0, 0, 1));
        long_line(W + 3, mk(1, 0, 7, 0, 0, 11));
        long_line(260, mk(1, 0, 7, 0, 0, 255));
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        chk("pending_results", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
